// File: rtl/ipv4_pkg.sv
// Shared types and constants for the IPv4 receive path.
// Header fields are kept as one packed record so the parser can capture them in place.
package ipv4_pkg;

    localparam logic [3:0]  IPV4_VERSION   = 4'd4;
    localparam logic [3:0]  IPV4_MIN_IHL   = 4'd5;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_OPT,
        S_PAYLOAD,
        S_DROP
    } ipv4_state_t;

    typedef enum logic [2:0] {
        NONE     = 3'd0,
        BAD_VER  = 3'd1,
        BAD_LEN  = 3'd2,
        BAD_CSUM = 3'd3,
        FRAG     = 3'd4,
        NOT_US   = 3'd5,
        TRUNC    = 3'd6
    } ipv4_err_t;

    // Only the header fields the parser acts on; DF and the reserved flag are not kept.
    typedef struct packed {
        logic [3:0]  ihl;
        logic [15:0] total_len;
        logic        mf;
        logic [12:0] frag_off;
        logic [7:0]  protocol;
        logic [31:0] src;
        logic [31:0] dst;
    } hdr_t;

endpackage

// File: rtl/ones_comp_acc.sv
// 16-bit one's-complement accumulator (clear, add word, folded sum); shared by IP/UDP/ICMP checksums.
// Latency: sum is combinational and already includes add_dat while add_vld is high.
// Backpressure: none; one word may be added every cycle.
module ones_comp_acc (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        add_vld,
    input  logic [15:0] add_dat,
    output logic [15:0] sum
);

    logic [15:0] acc;
    logic [16:0] raw;
    logic [15:0] folded;

    // End-around carry applied on every add keeps the stored value within 16 bits.
    assign raw    = {1'b0, acc} + {1'b0, add_dat};
    assign folded = raw[15:0] + {15'd0, raw[16]};
    assign sum    = add_vld ? folded : acc;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (add_vld) begin
            acc <= folded;
        end
    end

endmodule

// File: rtl/ipv4_decode.sv
// IPv4 receive header parser: validates the header, filters on destination, strips it, forwards payload.
// Latency: dout 1 cycle after din; hdr_ok/err 1 cycle after the deciding byte; done 1 cycle after dout_last.
// Backpressure: none; the byte stream cannot stall, so rejected frames are skipped until valid falls.
module ipv4_decode
    import ipv4_pkg::*;
#(
    parameter logic [31:0] IP_ADDR          = 32'h69696969,
    parameter bit          ACCEPT_BROADCAST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        dout_valid,
    output logic        dout_last,
    output logic        hdr_ok,
    output logic [31:0] src_ip,
    output logic [7:0]  protocol,
    output logic [15:0] payload_len,
    output logic        done,
    output logic        err,
    output logic [2:0]  err_code
);

    ipv4_state_t state, state_nxt;
    hdr_t        hdr;
    logic [5:0]  cnt;
    logic [7:0]  hi_byte;
    logic [15:0] pay_cnt;
    logic [15:0] csum;
    logic [5:0]  hdr_len;
    logic [15:0] pay_len_calc;
    logic [31:0] dst_full;
    logic        in_hdr;
    logic        hdr_last;
    logic        csum_add;
    logic        dst_match;
    logic        err_set;
    ipv4_err_t   err_code_nxt;
    logic        accept;

    assign hdr_len      = {hdr.ihl, 2'b00};
    assign in_hdr       = (state == S_HDR) || (state == S_OPT);
    assign hdr_last     = valid && in_hdr && (cnt == hdr_len - 6'd1);
    assign csum_add     = valid && in_hdr && cnt[0];
    assign pay_len_calc = hdr.total_len - {10'd0, hdr_len};
    // With a 20-byte header the last dst byte is still on din when the verdict is taken.
    assign dst_full     = (cnt == 6'd19) ? {hdr.dst[31:8], din} : hdr.dst;
    assign dst_match    = (dst_full == IP_ADDR) ||
                          (ACCEPT_BROADCAST && (dst_full == 32'hFFFF_FFFF));

    ones_comp_acc u_csum (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == S_IDLE),
        .add_vld (csum_add),
        .add_dat ({hi_byte, din}),
        .sum     (csum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        err_set      = 1'b0;
        err_code_nxt = NONE;
        accept       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (valid) begin
                    if ((din[7:4] != IPV4_VERSION) || (din[3:0] < IPV4_MIN_IHL)) begin
                        err_set      = 1'b1;
                        err_code_nxt = BAD_VER;
                        state_nxt    = S_DROP;
                    end else begin
                        state_nxt = S_HDR;
                    end
                end
            end
            S_HDR, S_OPT: begin
                if (!valid) begin
                    err_set      = 1'b1;
                    err_code_nxt = TRUNC;
                    state_nxt    = S_IDLE;
                end else if (hdr_last) begin
                    err_set = 1'b1;
                    if (hdr.total_len < {10'd0, hdr_len}) begin
                        err_code_nxt = BAD_LEN;
                    end else if (csum != 16'hFFFF) begin
                        err_code_nxt = BAD_CSUM;
                    end else if (hdr.mf || (hdr.frag_off != '0)) begin
                        err_code_nxt = FRAG;
                    end else if (!dst_match) begin
                        err_code_nxt = NOT_US;
                    end else begin
                        err_set = 1'b0;
                        accept  = 1'b1;
                    end
                    state_nxt = (accept && (pay_len_calc != '0)) ? S_PAYLOAD : S_DROP;
                end else if (cnt == 6'd19) begin
                    state_nxt = S_OPT;
                end
            end
            S_PAYLOAD: begin
                if (!valid) begin
                    err_set      = 1'b1;
                    err_code_nxt = TRUNC;
                    state_nxt    = S_IDLE;
                end else if (pay_cnt == 16'd1) begin
                    state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (!valid) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err         <= 1'b0;
            err_code    <= 3'd0;
            hdr_ok      <= 1'b0;
            done        <= 1'b0;
            src_ip      <= '0;
            protocol    <= '0;
            payload_len <= '0;
        end else begin
            err    <= err_set;
            hdr_ok <= accept;
            done   <= (accept && (pay_len_calc == '0)) || dout_last;
            if (err_set) begin
                err_code <= err_code_nxt;
            end
            if (accept) begin
                src_ip      <= hdr.src;
                protocol    <= hdr.protocol;
                payload_len <= pay_len_calc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr        <= '0;
            cnt        <= '0;
            hi_byte    <= '0;
            pay_cnt    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (valid) begin
                        cnt     <= 6'd1;
                        hi_byte <= din;
                        hdr.ihl <= din[3:0];
                    end
                end
                S_HDR, S_OPT: begin
                    if (valid) begin
                        cnt <= cnt + 6'd1;
                        if (!cnt[0]) begin
                            hi_byte <= din;
                        end
                        case (cnt)
                            6'd2:  hdr.total_len[15:8]          <= din;
                            6'd3:  hdr.total_len[7:0]           <= din;
                            6'd6:  {hdr.mf, hdr.frag_off[12:8]} <= din[5:0];
                            6'd7:  hdr.frag_off[7:0]            <= din;
                            6'd9:  hdr.protocol                 <= din;
                            6'd12: hdr.src[31:24]               <= din;
                            6'd13: hdr.src[23:16]               <= din;
                            6'd14: hdr.src[15:8]                <= din;
                            6'd15: hdr.src[7:0]                 <= din;
                            6'd16: hdr.dst[31:24]               <= din;
                            6'd17: hdr.dst[23:16]               <= din;
                            6'd18: hdr.dst[15:8]                <= din;
                            6'd19: hdr.dst[7:0]                 <= din;
                            default: ;
                        endcase
                        if (hdr_last) begin
                            pay_cnt <= pay_len_calc;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (valid) begin
                        dout       <= din;
                        dout_valid <= 1'b1;
                        dout_last  <= (pay_cnt == 16'd1);
                        pay_cnt    <= pay_cnt - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
